rr_log_packer: RTL
==================

# rr_log_packer

Inline, lossless record stage for the record/replay logger. It sits on NCH snooped AXI-style channels (e.g. AW/W/AR of pcis, or B/R of pcim) and passes valid/ready/data straight through. Every cycle in which one or more channels complete a handshake, it captures a record: a header bitmap followed by the compacted payloads of the channels that fired. It serialises that record into OUT_W-bit beats on a log stream and holds the channels off until the record has been fully emitted. This is the parametrised successor of the fixed hasAW/hasW/hasAR and hasB/hasR record formats.

## Interface
Parameters:
- NCH, 3: number of snooped channels; header is NCH bits, bit i = channel i.
- CH_W, 593: per-channel payload width. Narrower channels are zero-padded in the MSBs by the integrator.
- OUT_W, 512: log beat width.
- Derived: REC_W = NCH + NCH*CH_W; MAX_BEATS = ceil(REC_W/OUT_W).

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- rr_enable  in  1  recording enable
- up_valid  in  NCH  upstream valid per channel
- up_ready  out  NCH  upstream ready per channel
- up_data  in  NCH*CH_W  payloads; channel i occupies [i*CH_W +: CH_W]
- dn_valid  out  NCH  downstream valid
- dn_ready  in  NCH  downstream ready
- dn_data  out  NCH*CH_W  equals up_data (pure wire)
- log_valid  out  1  log beat valid
- log_ready  in  1  log beat accept
- log_data  out  OUT_W  log beat
- log_last  out  1  final beat of record
- rec_count  out  32  records captured, wraps at 2^32

## Operation
- States: IDLE, EMIT. Reset state is IDLE.
- Gate signal open = (state==IDLE).
  - up_ready = dn_ready & {NCH{open}}.
  - dn_valid = up_valid & {NCH{open}}.
- Fired vector f = up_valid & dn_ready & {NCH{open}}.
- IDLE, rr_enable=1, |f:
  - Latch rec[REC_W-1:0]: rec[NCH-1:0] = f.
  - The k-th fired channel in ascending index order goes to rec[NCH + k*CH_W +: CH_W].
  - All remaining bits are 0.
  - beats = ceil((NCH + popcount(f)*CH_W)/OUT_W), range 1..MAX_BEATS.
  - beat = 0; rec_count++; next state EMIT.
- IDLE, rr_enable=0 or f==0: stay in IDLE, no capture. The gate remains open, so the block behaves as pure pass-through.
- EMIT:
  - Gate closed; log_valid = 1.
  - log_data = rec[beat*OUT_W +: OUT_W], with bits beyond REC_W reading as 0.
  - log_last = (beat == beats-1).
  - On log_valid & log_ready: if last, go to IDLE; else beat++.
- rr_enable is sampled only in IDLE. Deasserting it during EMIT does not truncate the current record.
- The block never drops a record; backpressure on the log stream propagates to the channels through the gate.

## Timing
- Reset values: state IDLE, log_valid 0, log_last 0, log_data 0, rec 0, beat 0, rec_count 0. up_ready and dn_valid follow their combinational gate equations with open = 1.
- Capture latency: the first beat is valid the cycle after the firing handshake.
- A record of b beats closes the gate for at least b cycles. The gate reopens in the cycle after the last beat is accepted.
- Minimum record spacing is b+1 cycles.
- log_data and log_last are stable while log_valid & !log_ready.
- Simultaneous fires on several channels produce one record.
- A handshake cannot coincide with the last-beat transfer, because the gate is closed in EMIT.
- Asynchronous reset mid-EMIT discards the record. log_valid falls immediately and rec_count returns to 0.
- rec_count wraps from 0xFFFF_FFFF to 0 without any flag.

## Structure
- Shared rr package holds:
  - a generic header typedef, logic [NCH-1:0];
  - ceil-div and popcount constant functions;
  - the existing channel payload typedefs, used to build up_data.
- One sub-module, rr_payload_compact: combinational. Inputs f and up_data; outputs the compacted rec and beats.
- The top level holds the FSM, the beat counter, rec_count and the gating logic.

## Test plan
- Defaults; f=3'b010, up_data ch1 = 593-bit ramp, log_ready=1:
  - 2 beats.
  - beat0[2:0]=010, beat0[511:3]=payload[508:0].
  - beat1[83:0]=payload[592:509], rest of beat1 0; log_last on beat1.
  - up_ready=0 for 2 cycles.
  - rec_count=1.
- All three channels fire in one cycle (distinct patterns):
  - 4 beats, header 111.
  - Payload order ch0, ch1, ch2 at offsets 3, 596, 1189.
  - beat3 bits above 1781-1536 are 0.
- log_ready held 0 for 5 cycles on beat1 of 4:
  - log_data and log_last stable.
  - dn_valid=0 and up_ready=0 throughout.
  - Completes after log_ready is released.
- rr_enable=0 with 100 random handshakes: dn_valid==up_valid, log_valid never 1, rec_count=0.
- up_valid=111, dn_ready=000: no capture, state stays IDLE. Then dn_ready=100: one record, header 100, 2 beats.
- Cases during EMIT:
  - rst_n pulsed low during beat1 of 4: log_valid drops in the same cycle; after release the state is IDLE and rec_count=0.
  - rr_enable dropped during beat1: all 4 beats still emitted.

Source files
------------

// File: rtl/rr_log_packer_pkg.sv
// Shared record/replay definitions: default geometry, header and channel payload
// types, FSM encoding and the constant helpers used to size records.
package rr_log_packer_pkg;

  localparam int DEF_NCH   = 3;
  localparam int DEF_CH_W  = 593;
  localparam int DEF_OUT_W = 512;

  typedef logic [DEF_NCH-1:0]  rr_hdr_t;
  typedef logic [DEF_CH_W-1:0] rr_ch_payload_t;

  // Channel order matches the header bit order: ch0 in the LSBs of up_data.
  typedef struct packed {
    rr_ch_payload_t ar;
    rr_ch_payload_t w;
    rr_ch_payload_t aw;
  } rr_pcis_data_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } rr_state_e;

  function automatic int rr_ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int rr_popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rr_payload_compact.sv
// Builds one record from the fired vector: header bitmap in the LSBs, then the
// payloads of the fired channels packed back to back in ascending channel order.
module rr_payload_compact
  import rr_log_packer_pkg::*;
#(
  parameter  int NCH       = DEF_NCH,
  parameter  int CH_W      = DEF_CH_W,
  parameter  int OUT_W     = DEF_OUT_W,
  localparam int REC_W     = NCH + NCH * CH_W,
  localparam int MAX_BEATS = rr_ceil_div(REC_W, OUT_W),
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic [NCH-1:0]      f_i,
  input  logic [NCH*CH_W-1:0] up_data_i,
  output logic [REC_W-1:0]    rec_o,
  output logic [BEAT_W-1:0]   beats_o
);

  // Slot k is filled by the k-th set bit of f_i; unfilled slots stay zero.
  always_comb begin
    int k;
    rec_o          = '0;
    rec_o[NCH-1:0] = f_i;
    k              = 0;
    for (int i = 0; i < NCH; i++) begin
      if (f_i[i]) begin
        rec_o[NCH + k*CH_W +: CH_W] = up_data_i[i*CH_W +: CH_W];
        k = k + 1;
      end else begin
        k = k;
      end
    end
    beats_o = BEAT_W'(rr_ceil_div(NCH + rr_popcount(64'(f_i)) * CH_W, OUT_W));
  end

endmodule

// File: rtl/rr_log_packer.sv
// Inline record stage: passes channels through, captures one record per firing
// cycle and serialises it to the log stream while holding the channels off.
module rr_log_packer
  import rr_log_packer_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int CH_W  = DEF_CH_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rr_enable,
  input  logic [NCH-1:0]      up_valid,
  output logic [NCH-1:0]      up_ready,
  input  logic [NCH*CH_W-1:0] up_data,
  output logic [NCH-1:0]      dn_valid,
  input  logic [NCH-1:0]      dn_ready,
  output logic [NCH*CH_W-1:0] dn_data,
  output logic                log_valid,
  input  logic                log_ready,
  output logic [OUT_W-1:0]    log_data,
  output logic                log_last,
  output logic [31:0]         rec_count
);

  localparam int REC_W     = NCH + NCH * CH_W;
  localparam int MAX_BEATS = rr_ceil_div(REC_W, OUT_W);
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1);
  localparam int PAD_W     = MAX_BEATS * OUT_W;

  rr_state_e          state_q, state_d;
  logic [PAD_W-1:0]   rec_q, rec_d;
  logic [BEAT_W-1:0]  beats_q, beats_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [31:0]        rec_count_q, rec_count_d;
  logic               log_valid_q, log_valid_d;
  logic               log_last_q, log_last_d;
  logic [OUT_W-1:0]   log_data_q, log_data_d;

  logic               open_s;
  logic [NCH-1:0]     f_s;
  logic [REC_W-1:0]   rec_s;
  logic [BEAT_W-1:0]  beats_s;

  // The record is stored zero-padded to whole beats, so the tail beat reads 0 above REC_W.
  function automatic logic [OUT_W-1:0] beat_slice(input logic [PAD_W-1:0] r,
                                                  input logic [BEAT_W-1:0] idx);
    logic [OUT_W-1:0] s;
    s = '0;
    for (int j = 0; j < MAX_BEATS; j++) begin
      if (idx == BEAT_W'(j)) begin
        s = r[j*OUT_W +: OUT_W];
      end else begin
        s = s;
      end
    end
    return s;
  endfunction

  assign open_s   = (state_q == ST_IDLE);
  assign up_ready = dn_ready & {NCH{open_s}};
  assign dn_valid = up_valid & {NCH{open_s}};
  assign dn_data  = up_data;
  assign f_s      = up_valid & dn_ready & {NCH{open_s}};

  assign log_valid = log_valid_q;
  assign log_last  = log_last_q;
  assign log_data  = log_data_q;
  assign rec_count = rec_count_q;

  rr_payload_compact #(
    .NCH   (NCH),
    .CH_W  (CH_W),
    .OUT_W (OUT_W)
  ) u_compact (
    .f_i       (f_s),
    .up_data_i (up_data),
    .rec_o     (rec_s),
    .beats_o   (beats_s)
  );

  // Next-state logic: capture in IDLE, advance beats in EMIT; output beat is precomputed.
  always_comb begin
    state_d     = state_q;
    rec_d       = rec_q;
    beats_d     = beats_q;
    beat_d      = beat_q;
    rec_count_d = rec_count_q;
    log_valid_d = log_valid_q;
    log_last_d  = log_last_q;
    log_data_d  = log_data_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_enable && (|f_s)) begin
          state_d     = ST_EMIT;
          rec_d       = PAD_W'(rec_s);
          beats_d     = beats_s;
          beat_d      = '0;
          rec_count_d = rec_count_q + 32'd1;
          log_valid_d = 1'b1;
          log_data_d  = beat_slice(PAD_W'(rec_s), '0);
          log_last_d  = (beats_s == BEAT_W'(1));
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (log_ready) begin
          if (log_last_q) begin
            state_d     = ST_IDLE;
            beat_d      = '0;
            log_valid_d = 1'b0;
            log_last_d  = 1'b0;
            log_data_d  = '0;
          end else begin
            beat_d     = beat_q + BEAT_W'(1);
            log_data_d = beat_slice(rec_q, beat_q + BEAT_W'(1));
            log_last_d = ((beat_q + BEAT_W'(1)) == (beats_q - BEAT_W'(1)));
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        log_valid_d = 1'b0;
        log_last_d  = 1'b0;
      end
    endcase
  end

  // State, record buffer, counters and registered log outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rec_q       <= '0;
      beats_q     <= '0;
      beat_q      <= '0;
      rec_count_q <= 32'd0;
      log_valid_q <= 1'b0;
      log_last_q  <= 1'b0;
      log_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rec_q       <= rec_d;
      beats_q     <= beats_d;
      beat_q      <= beat_d;
      rec_count_q <= rec_count_d;
      log_valid_q <= log_valid_d;
      log_last_q  <= log_last_d;
      log_data_q  <= log_data_d;
    end
  end

endmodule
